// File: rtl/pps_edge_detect.sv
// Multi-channel PPS / time-mark edge detector: sync, glitch filter, edge pulses, event count, period.
// Latency: async input step to pe/ne high is SYNC_STAGES+FILT_CYC+1 clk edges; ev is combinational from pe/ne.
// Backpressure: none; free-running pulse outputs, every channel handles one edge per cycle.
//
// Ports:
//   clk, rst_n       system clock (rising edge), asynchronous active-low reset
//   sig[N_CH]        asynchronous inputs (GPS PPS, aux time marks)
//   mode[2*N_CH]     per-channel event select: bit 2i = count rises, bit 2i+1 = count falls
//   clr              synchronous clear of event counters and period arming, all channels
//   pe/ne[N_CH]      one-cycle qualified rising/falling edge pulses (not mode-masked)
//   ev[N_CH]         mode-masked event pulse
//   ev_cnt           per-channel wrapping event counter, ch i at [i*CNT_W +: CNT_W]
//   per_val          per-channel last rise-to-rise interval in clk cycles, ch i at [i*PER_W +: PER_W]
//   per_vld          one-cycle strobe when per_val is updated
//   per_ovf          interval saturated; held alongside per_val
module pps_edge_detect #(
  parameter int N_CH        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYC    = 4,
  parameter int CNT_W       = 16,
  parameter int PER_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         sig,
  input  logic [2*N_CH-1:0]       mode,
  input  logic                    clr,
  output logic [N_CH-1:0]         pe,
  output logic [N_CH-1:0]         ne,
  output logic [N_CH-1:0]         ev,
  output logic [N_CH*CNT_W-1:0]   ev_cnt,
  output logic [N_CH*PER_W-1:0]   per_val,
  output logic [N_CH-1:0]         per_vld,
  output logic [N_CH-1:0]         per_ovf
);

  // Filter counter only has to reach FILT_CYC-1; the toggle happens on the next differing sample.
  localparam int              FC_W    = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);
  localparam logic [PER_W-1:0] PER_MAX = '1;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_s;
    logic                   flt_q, flt_d;
    logic                   flt_dly_q;
    logic [FC_W-1:0]        fc_q, fc_d;
    logic                   pe_q, pe_d;
    logic                   ne_q, ne_d;
    logic                   ev_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PER_W-1:0]       per_cnt_q, per_cnt_d;
    logic [PER_W-1:0]       per_val_q, per_val_d;
    logic                   per_vld_q, per_vld_d;
    logic                   per_ovf_q, per_ovf_d;
    logic                   armed_q, armed_d;

    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig[g]};
      sync_s = sync_q[SYNC_STAGES-1];

      // Level only flips after FILT_CYC consecutive samples disagree with it.
      flt_d = flt_q;
      fc_d  = '0;
      if (sync_s != flt_q) begin
        if (fc_q == FC_LAST) begin
          flt_d = ~flt_q;
        end else begin
          fc_d = fc_q + FC_W'(1);
        end
      end

      // Edge pulses come out one edge after the filtered level moves.
      pe_d = flt_q & ~flt_dly_q;
      ne_d = ~flt_q & flt_dly_q;

      ev_s = (pe_q & mode[2*g]) | (ne_q & mode[2*g+1]);

      cnt_d = cnt_q;
      if (clr) begin
        cnt_d = '0;
      end else if (ev_s) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      // Period bookkeeping runs on pe_d so per_vld lines up with the pe pulse.
      per_cnt_d = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + PER_W'(1);
      armed_d   = armed_q;
      per_val_d = per_val_q;
      per_ovf_d = per_ovf_q;
      per_vld_d = 1'b0;
      if (clr) begin
        armed_d   = 1'b0;
        per_cnt_d = '0;
      end
      if (pe_d) begin
        // A rise coincident with clr only arms; it is the first edge of a new run.
        if (armed_q && !clr) begin
          per_vld_d = 1'b1;
          per_val_d = per_cnt_q;
          per_ovf_d = (per_cnt_q == PER_MAX);
        end
        armed_d   = 1'b1;
        // Restart at 1 so the count at the next rise equals the edge distance.
        per_cnt_d = PER_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= '0;
        flt_q     <= 1'b0;
        flt_dly_q <= 1'b0;
        fc_q      <= '0;
        pe_q      <= 1'b0;
        ne_q      <= 1'b0;
        cnt_q     <= '0;
        per_cnt_q <= '0;
        per_val_q <= '0;
        per_vld_q <= 1'b0;
        per_ovf_q <= 1'b0;
        armed_q   <= 1'b0;
      end else begin
        sync_q    <= sync_d;
        flt_q     <= flt_d;
        flt_dly_q <= flt_q;
        fc_q      <= fc_d;
        pe_q      <= pe_d;
        ne_q      <= ne_d;
        cnt_q     <= cnt_d;
        per_cnt_q <= per_cnt_d;
        per_val_q <= per_val_d;
        per_vld_q <= per_vld_d;
        per_ovf_q <= per_ovf_d;
        armed_q   <= armed_d;
      end
    end

    assign pe[g]                      = pe_q;
    assign ne[g]                      = ne_q;
    assign ev[g]                      = ev_s;
    assign ev_cnt[g*CNT_W +: CNT_W]   = cnt_q;
    assign per_val[g*PER_W +: PER_W]  = per_val_q;
    assign per_vld[g]                 = per_vld_q;
    assign per_ovf[g]                 = per_ovf_q;
  end

endmodule

// File: tb/tb_pps_edge_detect.sv
// Bench for pps_edge_detect: a 3-channel default-width instance plus a 1-channel narrow
// (CNT_W=2, PER_W=6) instance sharing channel 0 stimulus. An edge-indexed history model
// predicts every output each cycle; directed sequences add hand-computed spot checks.
module tb_pps_edge_detect;
  localparam int SS   = 2;
  localparam int FC   = 4;
  localparam int MAXE = 8000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  logic [2:0] sig   = 3'b000;
  logic [5:0] mode  = 6'b010101;

  logic [2:0]  pe_a, ne_a, ev_a, vld_a, ovf_a;
  logic [47:0] cnt_a;
  logic [95:0] pval_a;
  logic        pe_b, ne_b, ev_b, vld_b, ovf_b;
  logic [1:0]  cnt_b;
  logic [5:0]  pval_b;

  always #10 clk = ~clk;

  pps_edge_detect #(.N_CH(3)) u_a (
    .clk(clk), .rst_n(rst_n), .sig(sig), .mode(mode), .clr(clr),
    .pe(pe_a), .ne(ne_a), .ev(ev_a), .ev_cnt(cnt_a), .per_val(pval_a),
    .per_vld(vld_a), .per_ovf(ovf_a)
  );

  pps_edge_detect #(.N_CH(1), .CNT_W(2), .PER_W(6)) u_b (
    .clk(clk), .rst_n(rst_n), .sig(sig[0:0]), .mode(mode[1:0]), .clr(clr),
    .pe(pe_b), .ne(ne_b), .ev(ev_b), .ev_cnt(cnt_b), .per_val(pval_b),
    .per_vld(vld_b), .per_ovf(ovf_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (indexed by clk edge since reset release) ----------
  bit     samp [3][MAXE];
  bit     fltm [3][MAXE];
  int     n = 0;
  longint total [3];
  bit     armed [3];
  int     last  [3];
  longint ivl   [3];
  bit     pe_x  [3];
  bit     ne_x  [3];
  bit     vld_x [3];

  // Observations for the directed checks
  int     pe_obs [3];
  int     ne_obs [3];
  int     vld_obs[3];
  longint pe_t   [3];
  longint ne_t   [3];

  function automatic bit s_at(int c, int k);
    if (k - SS < 1) return 1'b0;
    return samp[c][k-SS];
  endfunction

  function automatic bit flt_at(int c, int k);
    if (k < 1) return 1'b0;
    return fltm[c][k];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      n = 0;
      for (int c = 0; c < 3; c++) begin
        total[c] = 0; armed[c] = 0; last[c] = 0; ivl[c] = 0;
        pe_x[c] = 0; ne_x[c] = 0; vld_x[c] = 0;
      end
      return;
    end
    n++;
    if (n >= MAXE) begin
      $display("FAIL model_capacity at %0t: edge %0d exceeds %0d", $time, n, MAXE);
      $fatal(1);
    end
    for (int c = 0; c < 3; c++) begin
      bit prev, tog, evp;
      samp[c][n] = sig[c];
      prev = flt_at(c, n-1);
      tog  = 1'b1;
      for (int k = 0; k < FC; k++) if (s_at(c, n-k) == prev) tog = 1'b0;
      fltm[c][n] = tog ? ~prev : prev;
      evp = (pe_x[c] & mode[2*c]) | (ne_x[c] & mode[2*c+1]);
      if (clr) total[c] = 0;
      else if (evp) total[c]++;
      pe_x[c]  = flt_at(c, n-1) & ~flt_at(c, n-2);
      ne_x[c]  = ~flt_at(c, n-1) & flt_at(c, n-2);
      vld_x[c] = 1'b0;
      if (pe_x[c]) begin
        if (armed[c] && !clr) begin
          vld_x[c] = 1'b1;
          ivl[c]   = n - last[c];
        end
        armed[c] = 1'b1;
        last[c]  = n;
      end else if (clr) begin
        armed[c] = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      longint cap32;
      cap32 = (ivl[c] >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : ivl[c];
      chk($sformatf("pe[%0d]", c), pe_a[c], pe_x[c]);
      chk($sformatf("ne[%0d]", c), ne_a[c], ne_x[c]);
      chk($sformatf("ev[%0d]", c), ev_a[c], (pe_x[c] & mode[2*c]) | (ne_x[c] & mode[2*c+1]));
      chk($sformatf("ev_cnt[%0d]", c), cnt_a[c*16 +: 16], total[c] % 65536);
      chk($sformatf("per_vld[%0d]", c), vld_a[c], vld_x[c]);
      chk($sformatf("per_val[%0d]", c), pval_a[c*32 +: 32], cap32);
      chk($sformatf("per_ovf[%0d]", c), ovf_a[c], ivl[c] >= 64'hFFFF_FFFF);
    end
    chk("b_pe", pe_b, pe_x[0]);
    chk("b_ne", ne_b, ne_x[0]);
    chk("b_ev", ev_b, (pe_x[0] & mode[0]) | (ne_x[0] & mode[1]));
    chk("b_ev_cnt", cnt_b, total[0] % 4);
    chk("b_per_vld", vld_b, vld_x[0]);
    chk("b_per_val", pval_b, (ivl[0] > 63) ? 63 : ivl[0]);
    chk("b_per_ovf", ovf_b, ivl[0] >= 63);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    for (int c = 0; c < 3; c++) begin
      if (pe_a[c])  begin pe_obs[c]++; pe_t[c] = $time; end
      if (ne_a[c])  begin ne_obs[c]++; ne_t[c] = $time; end
      if (vld_a[c]) vld_obs[c]++;
    end
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic clear_obs();
    for (int c = 0; c < 3; c++) begin
      pe_obs[c] = 0; ne_obs[c] = 0; vld_obs[c] = 0; pe_t[c] = 0; ne_t[c] = 0;
    end
  endtask

  // Directed interval table: {stimulus spacing in cycles, per_val narrow, per_ovf narrow}
  typedef struct {
    int spacing;
    int exp_val_b;
    bit exp_ovf_b;
  } per_vec_t;

  int P[3] = '{30, 44, 60};

  initial begin
    per_vec_t pv [3];
    int rem [3];
    int k;
    pv[0] = '{spacing: 50,  exp_val_b: 50, exp_ovf_b: 1'b0};
    pv[1] = '{spacing: 100, exp_val_b: 63, exp_ovf_b: 1'b1};
    pv[2] = '{spacing: 63,  exp_val_b: 63, exp_ovf_b: 1'b1};
    clear_obs();

    // Reset state
    #1;
    check_all();
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_pval_a", |pval_a, 0);
    #4 rst_n = 1'b1;

    // 1: step at t=105 -> single pe at 230 ns
    while ($time < 90) tick();
    #14 sig[0] = 1'b1;
    run(10);
    chk("t1_pe_time", pe_t[0], 231);
    chk("t1_pe_count", pe_obs[0], 1);
    chk("t1_ne_count", ne_obs[0], 0);
    chk("t1_ev_cnt", cnt_a[15:0], 1);
    sig[0] = 1'b0;
    run(20);
    chk("t1_ev_cnt_after_fall", cnt_a[15:0], 1);

    // 2: 3-cycle glitch rejected, 4-cycle pulse accepted
    clear_obs();
    sig[0] = 1'b1; run(3); sig[0] = 1'b0; run(20);
    chk("t2_glitch_pe", pe_obs[0], 0);
    chk("t2_glitch_ne", ne_obs[0], 0);
    chk("t2_glitch_cnt", cnt_a[15:0], 1);
    sig[0] = 1'b1; run(4); sig[0] = 1'b0; run(20);
    chk("t2_min_pe", pe_obs[0], 1);
    chk("t2_pe_ne_gap_ns", ne_t[0] - pe_t[0], 80);

    // 3: period measurement, table of spacings
    for (int v = 0; v < 3; v++) begin
      do_clr();
      clear_obs();
      for (int r = 0; r < 3; r++) begin
        sig[0] = 1'b1; run(10); sig[0] = 1'b0; run(pv[v].spacing - 10);
      end
      run(10);
      chk($sformatf("t3_vld_count[%0d]", v), vld_obs[0], 2);
      chk($sformatf("t3_per_val_a[%0d]", v), pval_a[31:0], pv[v].spacing);
      chk($sformatf("t3_per_ovf_a[%0d]", v), ovf_a[0], 0);
      chk($sformatf("t3_per_val_b[%0d]", v), pval_b, pv[v].exp_val_b);
      chk($sformatf("t3_per_ovf_b[%0d]", v), ovf_b, pv[v].exp_ovf_b);
    end

    // 4: mode and counter wrap
    do_clr();
    mode[1:0] = 2'b11;
    repeat (3) begin sig[0] = 1'b1; run(10); sig[0] = 1'b0; run(10); end
    run(20);
    chk("t4_both_cnt_a", cnt_a[15:0], 6);
    chk("t4_both_cnt_b", cnt_b, 2);
    mode[1:0] = 2'b10;
    do_clr();
    repeat (5) begin sig[0] = 1'b1; run(10); sig[0] = 1'b0; run(10); end
    run(20);
    chk("t4_fall_cnt_a", cnt_a[15:0], 5);
    chk("t4_wrap_cnt_b", cnt_b, 1);
    mode[1:0] = 2'b11;
    sig[0] = 1'b1;
    k = 0;
    while (!ev_a[0] && k < 30) begin tick(); k++; end
    chk("t4_ev_seen", ev_a[0], 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t4_clr_wins_a", cnt_a[15:0], 0);
    chk("t4_clr_wins_b", cnt_b, 0);
    sig[0] = 1'b0; run(20);

    // 5: independent channels, then simultaneous rises
    mode = 6'b111111;
    do_clr();
    for (int t = 0; t < 360; t++) begin
      for (int c = 0; c < 3; c++) sig[c] = ((t % P[c]) < 8);
      tick();
    end
    for (int c = 0; c < 3; c++) chk($sformatf("t5_per_val[%0d]", c), pval_a[c*32 +: 32], P[c]);
    sig = 3'b000; run(20);
    sig = 3'b111;
    k = 0;
    while (pe_a == 3'b000 && k < 30) begin tick(); k++; end
    chk("t5_simul_pe", pe_a, 3'b111);

    // 6: reset mid-pulse while inputs are high
    run(20);
    rst_n = 1'b0;
    run(3);
    chk("t6_rst_pe", pe_a, 0);
    chk("t6_rst_cnt", cnt_a, 0);
    chk("t6_rst_pval", |pval_a, 0);
    rst_n = 1'b1;
    k = 0;
    while (!pe_a[0] && k < 20) begin tick(); k++; end
    chk("t6_pe_edges", k, 7);
    chk("t6_no_vld", vld_a[0], 0);
    run(10);

    // Randomised pulse trains, mode changes and clears against the model
    for (int c = 0; c < 3; c++) rem[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if (rem[c] == 0) begin
          sig[c] = ~sig[c];
          rem[c] = int'($urandom_range(1, 12));
        end
        rem[c]--;
      end
      if ($urandom_range(0, 99) == 0) mode = 6'($urandom());
      clr = ($urandom_range(0, 149) == 0);
      tick();
    end
    clr = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
